pte_cache: RTL and testbench
============================

# pte_cache

Small direct-mapped cache of page-table entries sitting between the MMU page-table walker (`pt_walk_*` port) and the memory bus. It services walker PTE reads with a registered req/ack handshake and forwards misses to memory. On a miss it fills a line. On `flush` (SFENCE.VMA) it invalidates every line. Repeated walks over the same upper-level PTEs then hit in 2 cycles instead of paying full memory latency.

## Interface
- `DATA_WIDTH`, 32, PTE / bus data width.
- `ADDR_WIDTH`, 32, physical address width.
- `LINES`, 8, number of cache lines; power of two, ≥2.
  - `IDX = $clog2(LINES)`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ptw_req`  in  1  walker request; held with `ptw_addr` until `ptw_ack`.
- `ptw_addr`  in  ADDR_WIDTH  PTE physical address; bits [1:0] ignored.
- `ptw_data`  out  DATA_WIDTH  PTE returned; valid only while `ptw_ack`=1.
- `ptw_ack`  out  1  one-cycle response pulse.
- `flush`  in  1  invalidate all lines.
- `mem_req`  out  1  memory read request; held until `mem_ack`.
- `mem_addr`  out  ADDR_WIDTH  word-aligned read address.
- `mem_data`  in  DATA_WIDTH  read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory response, single cycle.
- `perf_hits`  out  32  hit counter.
- `perf_misses`  out  32  miss counter.

## Operation
- Address split:
  - index = `ptw_addr[IDX+1:2]`.
  - tag = `ptw_addr[ADDR_WIDTH-1:IDX+2]`.
- Per line storage: `valid`, tag, PTE data.
- State machine, states `IDLE`, `LOOKUP`, `MISS`, `RESP`:
  - `IDLE`: if `ptw_req`, latch `ptw_addr` and go to `LOOKUP`.
  - `LOOKUP`: hit (valid && tag match && !`flush`) → latch line data, go to `RESP`. Otherwise go to `MISS`.
  - `MISS`: `mem_req`=1 and `mem_addr`={latched addr[ADDR_WIDTH-1:2], 2'b00}. On `mem_ack`, latch `mem_data` and go to `RESP`.
    - Fill rule: write the line (valid=1, tag, data) only if `mem_data[0]` (PTE V bit)=1 and no flush was seen during this miss. Invalid PTEs are never cached.
  - `RESP`: `ptw_ack`=1 and `ptw_data`=latched value, then go to `IDLE`.
- `IDLE` accepts `ptw_req` high on the cycle right after `RESP`. Such a request is new: the walker drops `req` on its ack edge, or re-asserts it with the next-level address.
- Flush:
  - `flush`=1 clears all valid bits at that edge, in any state.
  - A lookup in the same cycle is forced to miss.
  - Flush during `MISS` sets a sticky "no-fill" flag, cleared on entering `IDLE`. Data is still returned to the walker.
  - Flush while a fill is being written (`mem_ack` cycle): flush wins, and the line stays invalid.
- `ptw_req` dropping mid-transaction is illegal. The block completes the transaction regardless.
- Reset mid-operation: return to `IDLE` immediately, all valid bits cleared, `mem_req` dropped. Memory must tolerate an abandoned request.

## Timing
- Reset values:
  - `ptw_ack`=0, `ptw_data`=0.
  - `mem_req`=0, `mem_addr`=0.
  - `perf_hits`=0, `perf_misses`=0.
  - state `IDLE`, all valid bits 0.
- Hit: `ptw_req` sampled at edge 0, `ptw_ack` high in cycle 2 (2-cycle latency).
- Miss: `mem_req` high from cycle 2. If `mem_ack` arrives in cycle k, `ptw_ack` is high in cycle k+1. Minimum miss latency is 3 cycles.
- `mem_req` and `mem_addr` decode directly from state and the address register. They are stable for the whole of `MISS`.
- `ptw_ack` never lasts more than 1 cycle. There are never two acks without an intervening `IDLE` cycle.

## Configuration
- With `PTE_CACHE_PERF_EN` defined:
  - `perf_hits` increments on each `LOOKUP` hit.
  - `perf_misses` increments on each `LOOKUP` miss.
  - Both saturate at 32'hFFFF_FFFF and are not cleared by `flush`.
- Without it: no counter flops are built, and both ports are tied to 0.

## Structure
- Shared package `mmu_pkg` holds:
  - `pte_cache_state_t` enum.
  - `PTE_V_BIT` constant (=0).
  - line struct `pte_line_t` {valid, tag, data}. Tag width is derived in the module.
- Sub-module `pte_cache_array`: valid/tag/data storage, with a single read index, a single write port and a flush-all input. The FSM stays in `pte_cache`.

## Test plan
- Reset, then read 0x0000_1004; memory returns 0x0000_2001 after 3 cycles → `mem_req` in cycles 2–4, `ptw_ack` in cycle 5 with data 0x0000_2001. Repeat the read → ack in cycle 2, `mem_req` stays 0, `perf_hits`=1, `perf_misses`=1 (macro on).
- Read 0x0000_1008; memory returns 0x0000_0000 (V=0) → data forwarded. Re-read misses again, so `mem_req` is asserted.
- Addresses 0x1004 and 0x1004+4·LINES (same index) alternately → each access misses and the line is replaced.
- Pulse `flush` during `MISS` for 0x3000 → data still acked. The next read of 0x3000 misses.
- Prime 0x1004, then `flush` coincident with the `LOOKUP` of 0x1004 → forced miss and memory access.
- Walker pattern: `ptw_req` held high across `RESP` with a new address → second lookup starts the cycle after the ack, with no lost or duplicated ack.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU types for the page-table-entry cache: FSM state encoding,
// PTE valid-bit position and the cache line record.
package mmu_pkg;

  localparam int MMU_DATA_W = 32;
  localparam int MMU_ADDR_W = 32;
  // Widest tag any legal configuration needs (LINES >= 2 leaves ADDR_W-3 bits).
  localparam int MMU_TAG_W  = MMU_ADDR_W - 3;

  localparam int PTE_V_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    RESP   = 2'd3
  } pte_cache_state_t;

  // Tags narrower than MMU_TAG_W are stored zero-extended.
  typedef struct packed {
    logic                  valid;
    logic [MMU_TAG_W-1:0]  tag;
    logic [MMU_DATA_W-1:0] data;
  } pte_line_t;

endpackage

// File: rtl/pte_cache_if.sv
// Registered req/ack read bus used both for the walker port and the memory port.
// The master drives req/addr and receives data/ack; the slave is the reverse.
interface pte_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  ack;

  modport master (output req, output addr, input data, input ack);
  modport slave  (input req, input addr, output data, output ack);

endinterface

// File: rtl/pte_cache_array.sv
// Direct-mapped line storage: one combinational read index, one write port,
// and a flush-all input that clears every valid bit and beats a same-cycle write.
module pte_cache_array
  import mmu_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [$clog2(LINES)-1:0] rd_idx_i,
  output pte_line_t                rd_line_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(LINES)-1:0] wr_idx_i,
  input  pte_line_t                wr_line_i
);

  logic [LINES-1:0]      valid_q;
  logic [MMU_TAG_W-1:0]  tag_q  [LINES];
  logic [MMU_DATA_W-1:0] data_q [LINES];

  // valid bits: reset and flush clear all, flush overrides a concurrent fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_line_i.valid;
    end
  end

  // tag/data payload needs no reset; it is qualified by valid
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      tag_q[wr_idx_i]  <= wr_line_i.tag;
      data_q[wr_idx_i] <= wr_line_i.data;
    end
  end

  assign rd_line_o.valid = valid_q[rd_idx_i];
  assign rd_line_o.tag   = tag_q[rd_idx_i];
  assign rd_line_o.data  = data_q[rd_idx_i];

endmodule

// File: rtl/pte_cache.sv
// Direct-mapped PTE cache between the page-table walker and the memory bus.
// Optional hit/miss counters are built only when PTE_CACHE_PERF_EN is defined;
// otherwise perf_hits/perf_misses are tied to zero.
//
// state  | meaning
// IDLE   | waiting for a walker request; clears the no-fill flag
// LOOKUP | index the array with the latched address, decide hit/miss
// MISS   | memory read outstanding; mem_req held until mem_ack
// RESP   | one-cycle ptw_ack with the latched PTE
module pte_cache
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINES      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  pte_cache_if.slave  ptw,
  pte_cache_if.master mem,
  input  logic        flush,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);

  localparam int IDX   = $clog2(LINES);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  pte_cache_state_t      state_q, state_d;
  logic [WA_W-1:0]       word_q, word_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  nofill_q, nofill_d;

  logic [IDX-1:0]        idx;
  logic [TAG_W-1:0]      tag;
  pte_line_t             rd_line;
  pte_line_t             wr_line;
  logic                  wr_en;
  logic                  hit;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^ptw.addr[1:0];

  assign idx = word_q[IDX-1:0];
  assign tag = word_q[WA_W-1:IDX];

  // A flush in the lookup cycle must not let a line that is being cleared hit.
  assign hit = rd_line.valid && (rd_line.tag == MMU_TAG_W'(tag)) && !flush;

  assign wr_line.valid = 1'b1;
  assign wr_line.tag   = MMU_TAG_W'(tag);
  assign wr_line.data  = MMU_DATA_W'(mem.data);

  pte_cache_array #(
    .LINES (LINES)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .rd_idx_i  (idx),
    .rd_line_o (rd_line),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx),
    .wr_line_i (wr_line)
  );

  // state, address, response data and no-fill flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      data_q   <= '0;
      nofill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      data_q   <= data_d;
      nofill_q <= nofill_d;
    end
  end

  // next-state, latching and fill decision
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    data_d   = data_q;
    nofill_d = nofill_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        nofill_d = 1'b0;
        if (ptw.req) begin
          word_d  = ptw.addr[ADDR_WIDTH-1:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_d  = DATA_WIDTH'(rd_line.data);
          state_d = RESP;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (flush) begin
          nofill_d = 1'b1;
        end
        if (mem.ack) begin
          data_d  = mem.data;
          // Invalid PTEs are never cached; a flush seen at any point of the
          // miss (including this cycle) means the data may be stale.
          wr_en   = mem.data[PTE_V_BIT] && !nofill_q && !flush;
          state_d = RESP;
        end
      end
      RESP: begin
        nofill_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ptw.ack  = (state_q == RESP);
  assign ptw.data = ptw.ack ? data_q : '0;
  assign mem.req  = (state_q == MISS);
  assign mem.addr = mem.req ? {word_q, 2'b00} : '0;

`ifdef PTE_CACHE_PERF_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  // saturating lookup outcome counters, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hits_q != 32'hFFFF_FFFF) begin
          hits_q <= hits_q + 32'd1;
        end
      end else if (misses_q != 32'hFFFF_FFFF) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_pte_cache.sv
// Directed bench for pte_cache: a table of walker reads with hand-computed
// ack cycle, data and hit/miss, plus hand sequences for back-to-back walks
// and reset in the middle of a miss.
module tb_pte_cache;
  import mmu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  pte_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ptw ();
  pte_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem ();

  pte_cache #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .LINES      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ptw         (ptw),
    .mem         (mem),
    .flush       (flush),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic [31:0] ret;
    int          flush_cyc;
    int          exp_ack;
    logic [31:0] exp_data;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int n);
`ifdef PTE_CACHE_PERF_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // One walker read. Cycle c is the interval after edge c-1; edge 0 is the
  // IDLE edge that samples ptw.req. The memory model acks `lat` cycles after
  // first seeing mem.req; flush pulses in cycle flush_cyc. Returns at the
  // negedge of the ack cycle with ptw.req still high.
  task automatic run_read(input string nm, input logic [31:0] addr, input int lat,
                          input logic [31:0] ret, input int flush_cyc, input bit cont,
                          input int exp_ack, input logic [31:0] exp_data, input bit exp_hit);
    int          ack_cyc;
    int          req_first;
    int          req_cnt;
    logic [31:0] got;
    bit          addr_bad;
    ack_cyc   = -1;
    req_first = -1;
    req_cnt   = 0;
    got       = '0;
    addr_bad  = 1'b0;
    if (!cont) begin
      @(negedge clk);
      ptw.req  = 1'b1;
      ptw.addr = addr;
    end else begin
      ptw.addr = addr;
      @(posedge clk);
      @(negedge clk);
    end
    check($sformatf("%s idle_no_ack", nm), {31'd0, ptw.ack}, 32'd0);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem.req) begin
        if (req_first < 0) req_first = c;
        req_cnt++;
        if (mem.addr !== (addr & ~32'h3)) addr_bad = 1'b1;
      end
      mem.ack  = mem.req && (c == req_first + lat - 1);
      mem.data = ret;
      flush    = (c == flush_cyc);
      if (ptw.ack) begin
        ack_cyc = c;
        got     = ptw.data;
        break;
      end
    end
    mem.ack = 1'b0;
    flush   = 1'b0;
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    check($sformatf("%s ack_cycle", nm), ack_cyc, exp_ack);
    check($sformatf("%s ack_data", nm), got, exp_data);
    if (exp_hit) begin
      check($sformatf("%s mem_req_cycles", nm), req_cnt, 32'd0);
    end else begin
      check($sformatf("%s mem_req_first", nm), req_first, 32'd2);
      check($sformatf("%s mem_req_cycles", nm), req_cnt, exp_ack - 2);
      check($sformatf("%s mem_addr", nm), {31'd0, addr_bad}, 32'd0);
    end
    check($sformatf("%s perf_hits", nm), perf_hits, perf_exp(exp_hits));
    check($sformatf("%s perf_misses", nm), perf_misses, perf_exp(exp_misses));
  endtask

  task automatic release_req(input string nm);
    @(negedge clk);
    ptw.req = 1'b0;
    check($sformatf("%s ack_one_cycle", nm), {31'd0, ptw.ack}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    //           addr          lat ret            flush ack data           hit
    vecs[0]  = '{32'h0000_1004, 3, 32'h0000_2001, -1, 5, 32'h0000_2001, 1'b0};
    vecs[1]  = '{32'h0000_1004, 1, 32'hDEAD_0001, -1, 2, 32'h0000_2001, 1'b1};
    vecs[2]  = '{32'h0000_1008, 1, 32'h0000_0000, -1, 3, 32'h0000_0000, 1'b0};
    vecs[3]  = '{32'h0000_1008, 2, 32'h0000_0005, -1, 4, 32'h0000_0005, 1'b0};
    vecs[4]  = '{32'h0000_1008, 1, 32'hDEAD_0001, -1, 2, 32'h0000_0005, 1'b1};
    vecs[5]  = '{32'h0000_1024, 1, 32'h0000_3001, -1, 3, 32'h0000_3001, 1'b0};
    vecs[6]  = '{32'h0000_1004, 1, 32'h0000_2001, -1, 3, 32'h0000_2001, 1'b0};
    vecs[7]  = '{32'h0000_1024, 1, 32'h0000_3001, -1, 3, 32'h0000_3001, 1'b0};
    vecs[8]  = '{32'h0000_1024, 1, 32'hDEAD_0001, -1, 2, 32'h0000_3001, 1'b1};
    vecs[9]  = '{32'h0000_2007, 1, 32'h0000_9001, -1, 3, 32'h0000_9001, 1'b0};
    vecs[10] = '{32'h0000_3000, 4, 32'h0000_4001,  3, 6, 32'h0000_4001, 1'b0};
    vecs[11] = '{32'h0000_3000, 1, 32'h0000_4001, -1, 3, 32'h0000_4001, 1'b0};
    vecs[12] = '{32'h0000_3003, 1, 32'hDEAD_0001, -1, 2, 32'h0000_4001, 1'b1};
    vecs[13] = '{32'h0000_1004, 1, 32'h0000_2001, -1, 3, 32'h0000_2001, 1'b0};
    vecs[14] = '{32'h0000_1004, 1, 32'h0000_2001,  1, 3, 32'h0000_2001, 1'b0};
    vecs[15] = '{32'h0000_1004, 1, 32'hDEAD_0001, -1, 2, 32'h0000_2001, 1'b1};
    vecs[16] = '{32'h0000_1010, 2, 32'h0000_7001,  3, 4, 32'h0000_7001, 1'b0};
    vecs[17] = '{32'h0000_1010, 1, 32'h0000_7001, -1, 3, 32'h0000_7001, 1'b0};

    rst_n    = 1'b0;
    flush    = 1'b0;
    ptw.req  = 1'b0;
    ptw.addr = '0;
    mem.ack  = 1'b0;
    mem.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ptw_ack", {31'd0, ptw.ack}, 32'd0);
    check("reset ptw_data", ptw.data, 32'd0);
    check("reset mem_req", {31'd0, mem.req}, 32'd0);
    check("reset mem_addr", mem.addr, 32'd0);
    check("reset perf_hits", perf_hits, 32'd0);
    check("reset perf_misses", perf_misses, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].ret,
               vecs[i].flush_cyc, 1'b0, vecs[i].exp_ack, vecs[i].exp_data, vecs[i].exp_hit);
      release_req($sformatf("vec%0d", i));
    end

    // Walker keeps req high across RESP and swaps in the next-level address.
    run_read("b2b0", 32'h0000_1004, 1, 32'h0000_2001, -1, 1'b0, 3, 32'h0000_2001, 1'b0);
    run_read("b2b1", 32'h0000_1010, 1, 32'hDEAD_0001, -1, 1'b1, 2, 32'h0000_7001, 1'b1);
    run_read("b2b2", 32'h0000_1004, 1, 32'hDEAD_0001, -1, 1'b1, 2, 32'h0000_2001, 1'b1);
    release_req("b2b2");

    // Reset while a miss is outstanding: mem_req drops at once, lines are lost.
    @(negedge clk);
    ptw.req  = 1'b1;
    ptw.addr = 32'h0000_5000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid mem_req_before", {31'd0, mem.req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid mem_req", {31'd0, mem.req}, 32'd0);
    check("rst_mid mem_addr", mem.addr, 32'd0);
    check("rst_mid ptw_ack", {31'd0, ptw.ack}, 32'd0);
    check("rst_mid perf_misses", perf_misses, 32'd0);
    ptw.req    = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_read("post_rst", 32'h0000_1004, 1, 32'h0000_2001, -1, 1'b0, 3, 32'h0000_2001, 1'b0);
    release_req("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
